// File: rtl/prbs_burst_arb_if.sv
// rtl/prbs_burst_arb_if.sv - request/burst bus between the PRBS arbiter and its two requesters
interface prbs_burst_arb_if #(
    parameter int LEN_W = 8
) ();
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic             seed_ld;
    logic [3:0]       seed;
    logic [1:0]       gnt;
    logic             y;
    logic             y_vld;
    logic [1:0]       done;
    logic             busy;

    modport master (
        output req, len0, len1, seed_ld, seed,
        input  gnt, y, y_vld, done, busy
    );

    modport slave (
        input  req, len0, len1, seed_ld, seed,
        output gnt, y, y_vld, done, busy
    );
endinterface

// File: rtl/prbs_burst_arb.sv
// rtl/prbs_burst_arb.sv - round-robin arbiter streaming bursts of one shared 4-bit PRBS to two requesters
module prbs_burst_arb #(
    parameter logic [3:0] SEED  = 4'b1111,
    parameter int         LEN_W = 8
) (
    input  logic          clk,
    input  logic          res,
    prbs_burst_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [3:0]       d, d_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             w, w_n;
    logic             ptr, ptr_n;
    logic [1:0]       gnt_q, gnt_n;
    logic             win;
    logic [LEN_W-1:0] lenw;

    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
            d     <= SEED;
            cnt   <= '0;
            w     <= 1'b0;
            ptr   <= 1'b0;
            gnt_q <= 2'b00;
        end else begin
            state <= state_n;
            d     <= d_n;
            cnt   <= cnt_n;
            w     <= w_n;
            ptr   <= ptr_n;
            gnt_q <= gnt_n;
        end
    end

    // Contention goes to ptr; a lone requester wins outright.
    always_comb begin
        win  = (bus.req == 2'b11) ? ptr : bus.req[1];
        lenw = win ? bus.len1 : bus.len0;
    end

    always_comb begin
        state_n = state;
        d_n     = d;
        cnt_n   = cnt;
        w_n     = w;
        ptr_n   = ptr;
        gnt_n   = gnt_q;
        case (state)
            IDLE: begin
                if (bus.seed_ld) begin
                    d_n = (bus.seed == 4'b0000) ? SEED : bus.seed;
                end
                if (bus.req != 2'b00) begin
                    w_n = win;
                    if (lenw == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        gnt_n   = win ? 2'b10 : 2'b01;
                        cnt_n   = lenw;
                    end
                end
            end
            RUN: begin
                d_n   = {d[3] ^ d[0], d[3:1]};
                cnt_n = cnt - LEN_W'(1);
                // A dropped request ends the burst early; it outranks normal completion.
                if (!bus.req[w]) begin
                    state_n = IDLE;
                    gnt_n   = 2'b00;
                    ptr_n   = ~w;
                end else if (cnt == LEN_W'(1)) begin
                    state_n = DONE;
                    gnt_n   = 2'b00;
                end
            end
            DONE: begin
                ptr_n   = ~w;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 2'b00;
            end
        endcase
    end

    always_comb begin
        bus.gnt   = gnt_q;
        bus.y_vld = (state == RUN);
        bus.y     = (state == RUN) & d[0];
        bus.done  = (state == DONE) ? (w ? 2'b10 : 2'b01) : 2'b00;
        bus.busy  = (state != IDLE);
    end
endmodule

// File: tb/tb_prbs_burst_arb.sv
// tb/tb_prbs_burst_arb.sv - scoreboard bench for prbs_burst_arb against an m-sequence position model
module tb_prbs_burst_arb;
    typedef struct {
        logic [1:0] g;
        logic       b;
    } bit_t;
    typedef struct {
        logic [1:0] who;
        logic       after_bits;
    } done_t;

    logic clk = 1'b0;
    logic res;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    logic prev_vld = 1'b0;

    logic [14:0] seq = 15'b000100110101111;
    int          p = 0;
    bit          ptr = 1'b0;
    bit_t        bq[$];
    done_t       dq[$];

    always #5 clk = ~clk;

    prbs_burst_arb_if #(.LEN_W(8)) bus ();

    prbs_burst_arb #(.SEED(4'b1111), .LEN_W(8)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic int pos_of(input logic [3:0] s);
        for (int q = 0; q < 15; q++) begin
            bit ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (seq[(q + i) % 15] != s[i]) ok = 1'b0;
            end
            if (ok) return q;
        end
        return 0;
    endfunction

    task automatic push_burst(input bit w, input int n, input bit with_done);
        bit_t  e;
        done_t de;
        for (int i = 0; i < n; i++) begin
            e.g = w ? 2'b10 : 2'b01;
            e.b = seq[p];
            bq.push_back(e);
            p = (p + 1) % 15;
        end
        if (with_done) begin
            de.who        = w ? 2'b10 : 2'b01;
            de.after_bits = (n > 0);
            dq.push_back(de);
        end
        ptr = ~w;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.y_vld) begin
                if (bq.size() == 0) begin
                    chk("unexpected_bit", 32'(bus.y_vld), 0);
                end else begin
                    bit_t e;
                    e = bq.pop_front();
                    chk("y_bit", 32'(bus.y), 32'(e.b));
                    chk("gnt_run", 32'(bus.gnt), 32'(e.g));
                end
            end else begin
                chk("y_idle", 32'(bus.y), 0);
                chk("gnt_idle", 32'(bus.gnt), 0);
            end
            if (bus.done != 2'b00) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 0);
                end else begin
                    done_t de;
                    de = dq.pop_front();
                    chk("done_who", 32'(bus.done), 32'(de.who));
                    chk("done_lat", 32'(prev_vld), 32'(de.after_bits));
                end
            end
            chk("busy", 32'(bus.busy), 32'(bus.y_vld || (bus.done != 2'b00)));
        end
        prev_vld = bus.y_vld;
    end

    // Issue one arbitration round from IDLE; abort_k >= 0 drops req after abort_k+1 bits.
    task automatic do_round(input logic [1:0] r, input int l0, input int l1,
                            input bit sld, input logic [3:0] sv, input int abort_k);
        bit first;
        int nd_exp;
        int nd = 0;
        int t = 0;
        int c = 0;
        if (sld) p = pos_of((sv == 4'b0000) ? 4'b1111 : sv);
        first = (r == 2'b11) ? ptr : r[1];
        if (abort_k >= 0) begin
            push_burst(first, abort_k + 1, 1'b0);
            nd_exp = 0;
        end else begin
            push_burst(first, first ? l1 : l0, 1'b1);
            if (r == 2'b11) push_burst(~first, first ? l0 : l1, 1'b1);
            nd_exp = (r == 2'b11) ? 2 : 1;
        end
        bus.req     = r;
        bus.len0    = 8'(l0);
        bus.len1    = 8'(l1);
        bus.seed_ld = sld;
        bus.seed    = sv;
        while (t < 400) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                bus.seed_ld = 1'b0;
                chk("first_lat", 32'(bus.y_vld), 32'(((first ? l1 : l0) > 0)));
            end
            if (abort_k >= 0 && t == abort_k + 1) bus.req = 2'b00;
            if (bus.done != 2'b00) begin
                nd++;
                bus.req = bus.req & ~bus.done;
            end
            if ((abort_k >= 0) ? (t >= abort_k + 1) : (nd >= nd_exp)) break;
        end
        chk("round_timeout", 32'(t >= 400), 0);
        bus.req = 2'b00;
        while ((bq.size() != 0 || dq.size() != 0) && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("drain", 32'(bq.size() + dq.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int l0, l1, k;
        logic [1:0] r;
        res         = 1'b1;
        bus.req     = 2'b00;
        bus.len0    = '0;
        bus.len1    = '0;
        bus.seed_ld = 1'b0;
        bus.seed    = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_vld", 32'(bus.y_vld), 0);
        chk("rst_y", 32'(bus.y), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        res    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        do_round(2'b01, 15, 0, 1'b0, 4'h0, -1);
        do_round(2'b11, 4, 4, 1'b0, 4'h0, -1);
        do_round(2'b01, 4, 0, 1'b0, 4'h0, -1);
        do_round(2'b01, 3, 0, 1'b1, 4'h0, -1);
        do_round(2'b10, 0, 3, 1'b1, 4'h8, -1);
        do_round(2'b01, 10, 0, 1'b0, 4'h0, 3);
        do_round(2'b11, 2, 3, 1'b0, 4'h0, -1);
        do_round(2'b10, 0, 0, 1'b0, 4'h0, -1);
        do_round(2'b01, 5, 0, 1'b0, 4'h0, -1);

        push_burst(1'b0, 20, 1'b1);
        bus.req  = 2'b01;
        bus.len0 = 8'd20;
        repeat (6) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", 32'(bus.gnt), 0);
        chk("midrst_vld", 32'(bus.y_vld), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        res     = 1'b0;
        bus.req = 2'b00;
        bq.delete();
        dq.delete();
        p   = 0;
        ptr = 1'b0;
        @(negedge clk);
        do_round(2'b01, 2, 0, 1'b0, 4'h0, -1);

        for (int it = 0; it < 60; it++) begin
            r  = 2'($urandom_range(1, 3));
            l0 = ($urandom_range(0, 5) == 0) ? $urandom_range(7, 20) : $urandom_range(0, 6);
            l1 = ($urandom_range(0, 5) == 0) ? $urandom_range(7, 20) : $urandom_range(0, 6);
            k  = -1;
            if (r != 2'b11 && $urandom_range(0, 2) == 0) begin
                if ((r[1] ? l1 : l0) >= 2) k = $urandom_range(0, (r[1] ? l1 : l0) - 2);
            end
            do_round(r, l0, l1, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom), k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
